// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame arbiter.
// Holds the pixel/address widths, the write-buffer entry type and the swap FSM states.
package fb_pkg;

  localparam int unsigned FB_WORDS_DEF = 76800;
  localparam int unsigned PIX_W        = 16;
  localparam int unsigned ADDR_W       = 17;
  localparam int unsigned MEM_AW       = ADDR_W + 1;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    addr_t addr;
    pix_t  data;
  } wr_entry_t;

  typedef enum logic {
    SW_IDLE = 1'b0,
    SW_PEND = 1'b1
  } swap_state_e;

  function automatic logic addr_in_range(input addr_t addr, input int unsigned limit);
    return 32'(addr) < limit;
  endfunction

endpackage

// File: rtl/fb_wfifo.sv
// Synchronous write-buffer FIFO holding camera {addr, data} entries.
// Depth must be a power of two so the pointers wrap by natural overflow.
module fb_wfifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  wr_entry_t              i_push_data,
  input  logic                   i_pop,
  output wr_entry_t              o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wr_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port RAM arbiter for a double-buffered frame: display reads win every cycle,
// camera writes are buffered and drained into the back bank, bank swap waits for vsync.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned FB_WORDS    = FB_WORDS_DEF,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [16:0]       rd_addr,
  output logic              rd_valid,
  output logic [15:0]       rd_data,
  input  logic              rd_frame_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [16:0]       wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              wr_frame_done,
  output logic [17:0]       mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              rd_bank
);

  localparam int unsigned CNT_W = $clog2(WFIFO_DEPTH) + 1;

  logic             r_rd_valid;
  logic             r_rd_inr;
  logic             r_rd_bank;
  swap_state_e      r_sw_state;
  swap_state_e      w_sw_next;
  logic             w_swap;
  logic             w_swap_ok;
  logic             w_rd_inr;
  logic             w_rd_acc;
  logic             w_push;
  logic             w_pop;
  logic             w_we;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  wr_entry_t        w_head;
  wr_entry_t        w_push_data;

  assign w_push_data = '{addr: wr_addr, data: wr_data};
  assign w_push      = wr_valid && !w_full;

  fb_wfifo #(
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Out-of-range reads never touch the RAM, so their slot goes to the write drain.
  assign w_rd_inr = addr_in_range(rd_addr, FB_WORDS);
  assign w_rd_acc = rd_req && w_rd_inr;
  assign w_pop    = !w_empty && !w_rd_acc;
  assign w_we     = w_pop && addr_in_range(w_head.addr, FB_WORDS);

  always_comb begin
    mem_addr = '0;
    if (w_rd_acc) begin
      mem_addr = {r_rd_bank, rd_addr};
    end else if (w_pop) begin
      mem_addr = {~r_rd_bank, w_head.addr};
    end
  end

  assign mem_we    = w_we;
  assign mem_wdata = w_head.data;
  assign wr_ready  = (w_count != CNT_W'(WFIFO_DEPTH));
  assign rd_valid  = r_rd_valid;
  assign rd_data   = (r_rd_valid && r_rd_inr) ? mem_rdata : '0;
  assign rd_bank   = r_rd_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_inr   <= 1'b0;
      r_rd_bank  <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      r_rd_inr   <= w_rd_inr;
      r_rd_bank  <= r_rd_bank ^ w_swap;
    end
  end

  // Swap FSM: state register, next-state logic, output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sw_state <= SW_IDLE;
    else        r_sw_state <= w_sw_next;
  end

  assign w_swap_ok = rd_frame_start && w_empty && !w_we;

  always_comb begin
    w_sw_next = r_sw_state;
    unique case (r_sw_state)
      SW_IDLE: if (wr_frame_done) w_sw_next = SW_PEND;
      SW_PEND: if (w_swap_ok)     w_sw_next = SW_IDLE;
    endcase
  end

  always_comb begin
    w_swap = (r_sw_state == SW_PEND) && w_swap_ok;
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: a per-cycle vector table plus hand-written
// sequences for contention, range, bank swap, deferred swap and mid-drain reset.
module tb_fb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_frame_start;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_frame_done;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        rd_bank;

  int n_tests = 0;
  int n_fail  = 0;

  fb_arbiter #(
    .FB_WORDS    (76800),
    .WFIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_frame_start (rd_frame_start),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_frame_done  (wr_frame_done),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .rd_bank        (rd_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd_req;
    logic [16:0] rd_addr;
    logic [15:0] mem_rdata;
    logic        wr_valid;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        e_rd_valid;
    logic [15:0] e_rd_data;
    logic [17:0] e_mem_addr;
    logic        e_mem_we;
    logic [15:0] e_wdata;
    logic        e_wr_ready;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_inputs();
    rd_req = 1'b0; rd_addr = '0; rd_frame_start = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_frame_done = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance to the next cycle's drive point and clear single-cycle pulses.
  task automatic next_cyc();
    @(negedge clk);
    rd_frame_start = 1'b0;
    wr_frame_done  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    clr_inputs();

    // rd_req rd_addr mem_rdata wr_valid wr_addr wr_data | rd_valid rd_data mem_addr we wdata ready
    vecs[0]  = '{1'b1, 17'd100,   16'h0000, 1'b0, 17'd0,     16'h0000,
                 1'b0, 16'h0000, 18'd100,    1'b0, 16'h0000, 1'b1};
    vecs[1]  = '{1'b0, 17'd0,     16'hF800, 1'b0, 17'd0,     16'h0000,
                 1'b1, 16'hF800, 18'd0,      1'b0, 16'h0000, 1'b1};
    vecs[2]  = '{1'b1, 17'd76800, 16'h1234, 1'b0, 17'd0,     16'h0000,
                 1'b0, 16'h0000, 18'd0,      1'b0, 16'h0000, 1'b1};
    vecs[3]  = '{1'b0, 17'd0,     16'hABCD, 1'b0, 17'd0,     16'h0000,
                 1'b1, 16'h0000, 18'd0,      1'b0, 16'h0000, 1'b1};
    vecs[4]  = '{1'b0, 17'd0,     16'h0000, 1'b1, 17'd5,     16'h1111,
                 1'b0, 16'h0000, 18'd0,      1'b0, 16'h0000, 1'b1};
    vecs[5]  = '{1'b0, 17'd0,     16'h0000, 1'b0, 17'd0,     16'h0000,
                 1'b0, 16'h0000, 18'd131077, 1'b1, 16'h1111, 1'b1};
    vecs[6]  = '{1'b1, 17'd3,     16'h0000, 1'b1, 17'd7,     16'h2222,
                 1'b0, 16'h0000, 18'd3,      1'b0, 16'h0000, 1'b1};
    vecs[7]  = '{1'b1, 17'd76800, 16'h5555, 1'b0, 17'd0,     16'h0000,
                 1'b1, 16'h5555, 18'd131079, 1'b1, 16'h2222, 1'b1};
    vecs[8]  = '{1'b0, 17'd0,     16'h7777, 1'b0, 17'd0,     16'h0000,
                 1'b1, 16'h0000, 18'd0,      1'b0, 16'h0000, 1'b1};
    vecs[9]  = '{1'b0, 17'd0,     16'h0000, 1'b1, 17'd76800, 16'h3333,
                 1'b0, 16'h0000, 18'd0,      1'b0, 16'h0000, 1'b1};
    vecs[10] = '{1'b0, 17'd0,     16'h0000, 1'b0, 17'd0,     16'h0000,
                 1'b0, 16'h0000, 18'd207872, 1'b0, 16'h0000, 1'b1};
    vecs[11] = '{1'b0, 17'd0,     16'h0000, 1'b0, 17'd0,     16'h0000,
                 1'b0, 16'h0000, 18'd0,      1'b0, 16'h0000, 1'b1};

    // Reset values while rst_n is held low.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset rd_bank", 32'(rd_bank), 0);
    chk("reset rd_valid", 32'(rd_valid), 0);
    chk("reset rd_data", 32'(rd_data), 0);
    chk("reset mem_we", 32'(mem_we), 0);
    chk("reset mem_addr", 32'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("reset wr_ready", 32'(wr_ready), 1);

    // Table: one row per cycle, starting from an empty FIFO with rd_bank=0.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rd_req    = vecs[i].rd_req;
      rd_addr   = vecs[i].rd_addr;
      mem_rdata = vecs[i].mem_rdata;
      wr_valid  = vecs[i].wr_valid;
      wr_addr   = vecs[i].wr_addr;
      wr_data   = vecs[i].wr_data;
      #1;
      chk($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rd_valid));
      if (vecs[i].e_rd_valid)
        chk($sformatf("row%0d rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd_data));
      chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_mem_addr));
      chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_mem_we));
      if (vecs[i].e_mem_we)
        chk($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wdata));
      chk($sformatf("row%0d wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_wr_ready));
    end

    // Contention: reads hold the port for 10 cycles while 6 writes are offered.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      next_cyc();
      rd_req   = 1'b1;
      rd_addr  = 17'd200;
      wr_valid = (c < 6);
      wr_addr  = 17'(1000 + c);
      wr_data  = 16'(16'hA000 + c);
      #1;
      chk($sformatf("cont c%0d mem_we", c), 32'(mem_we), 0);
      chk($sformatf("cont c%0d mem_addr", c), 32'(mem_addr), 200);
      chk($sformatf("cont c%0d wr_ready", c), 32'(wr_ready), (c < 4) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      rd_req   = 1'b0;
      wr_valid = 1'b0;
      #1;
      chk($sformatf("drain k%0d mem_we", k), 32'(mem_we), 1);
      chk($sformatf("drain k%0d mem_addr", k), 32'(mem_addr), 131072 + 1000 + k);
      chk($sformatf("drain k%0d mem_wdata", k), 32'(mem_wdata), 32'h0000A000 + k);
    end
    next_cyc();
    #1;
    chk("drain done mem_we", 32'(mem_we), 0);
    chk("drain done wr_ready", 32'(wr_ready), 1);

    // Swap with empty FIFO: frame done, then vsync five cycles later.
    do_reset();
    wr_frame_done = 1'b1;
    for (int c = 0; c < 5; c++) next_cyc();
    rd_frame_start = 1'b1;
    #1;
    chk("swap before", 32'(rd_bank), 0);
    next_cyc();
    #1;
    chk("swap after", 32'(rd_bank), 1);
    wr_valid = 1'b1; wr_addr = 17'd9; wr_data = 16'hBEEF;
    next_cyc();
    wr_valid = 1'b0;
    #1;
    chk("swap wr mem_we", 32'(mem_we), 1);
    chk("swap wr mem_addr", 32'(mem_addr), 9);

    // Second done while pending must not arm a second swap.
    next_cyc();
    wr_frame_done = 1'b1;
    next_cyc();
    wr_frame_done = 1'b1;
    next_cyc();
    rd_frame_start = 1'b1;
    next_cyc();
    #1;
    chk("single swap", 32'(rd_bank), 0);
    rd_frame_start = 1'b1;
    next_cyc();
    #1;
    chk("no extra swap", 32'(rd_bank), 0);

    // Done and vsync together: arm only, swap on the next vsync.
    wr_frame_done = 1'b1;
    rd_frame_start = 1'b1;
    next_cyc();
    #1;
    chk("coincide no swap", 32'(rd_bank), 0);
    next_cyc();
    rd_frame_start = 1'b1;
    next_cyc();
    #1;
    chk("coincide later swap", 32'(rd_bank), 1);

    // Deferred swap: two writes still buffered at vsync (reads hold the port).
    rd_req = 1'b1; rd_addr = 17'd10;
    wr_valid = 1'b1; wr_addr = 17'd20; wr_data = 16'h0020; wr_frame_done = 1'b1;
    next_cyc();
    rd_req = 1'b1; wr_valid = 1'b1; wr_addr = 17'd21; wr_data = 16'h0021;
    next_cyc();
    rd_req = 1'b1; wr_valid = 1'b0; rd_frame_start = 1'b1;
    #1;
    chk("defer count", 32'(dut.w_count), 2);
    next_cyc();
    rd_req = 1'b0;
    #1;
    chk("defer no swap", 32'(rd_bank), 1);
    chk("defer drain0 addr", 32'(mem_addr), 20);
    chk("defer drain0 we", 32'(mem_we), 1);
    next_cyc();
    #1;
    chk("defer drain1 addr", 32'(mem_addr), 21);
    next_cyc();
    rd_frame_start = 1'b1;
    next_cyc();
    #1;
    chk("defer swap", 32'(rd_bank), 0);

    // Reset mid-drain with bank=1, three entries queued and a swap pending.
    wr_frame_done = 1'b1; rd_frame_start = 1'b1;
    next_cyc();
    rd_frame_start = 1'b1;
    next_cyc();
    #1;
    chk("pre-reset bank", 32'(rd_bank), 1);
    for (int k = 0; k < 3; k++) begin
      rd_req = 1'b1; rd_addr = 17'd1;
      wr_valid = 1'b1; wr_addr = 17'(300 + k); wr_data = 16'(k);
      wr_frame_done = (k == 1);
      next_cyc();
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    #1;
    chk("pre-reset mem_we", 32'(mem_we), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset mem_we", 32'(mem_we), 0);
    chk("mid reset count", 32'(dut.w_count), 0);
    chk("mid reset rd_bank", 32'(rd_bank), 0);
    chk("mid reset mem_addr", 32'(mem_addr), 0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    rd_frame_start = 1'b1;
    #1;
    chk("post reset wr_ready", 32'(wr_ready), 1);
    chk("post reset mem_we", 32'(mem_we), 0);
    next_cyc();
    #1;
    chk("post reset no swap", 32'(rd_bank), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
